// File: rtl/mel_pkg.sv
// Constants, FSM encoding and saturating arithmetic shared by the log-mel
// framing path (window, FFT scaling and overlap-add stages).
package mel_pkg;

  localparam int FRAME_LEN  = 1024;
  localparam int HOP_LEN    = FRAME_LEN / 2;
  localparam int NUM_FRAMES = 177;
  localparam int TOTAL_DATA = (NUM_FRAMES + 1) * HOP_LEN;

  typedef enum logic [1:0] {
    OLA_RUN   = 2'd0,
    OLA_FLUSH = 2'd1,
    OLA_DONE  = 2'd2
  } ola_state_t;

  // Adds two sign-extended operands and clamps the sum to a signed range of
  // 'width' bits; the caller keeps the low 'width' bits of the result.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned width);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a};
    s  = s + {b[31], b};
    hi = 33'sd1 <<< (width - 1);
    hi = hi - 33'sd1;
    lo = ~hi;
    if (s > hi)      return hi[31:0];
    else if (s < lo) return lo[31:0];
    else             return s[31:0];
  endfunction

endpackage

// File: rtl/ola_buf.sv
// Overlap store for the second half of the previous frame: one synchronous
// write port, one combinational read port, cleared by reset.
module ola_buf #(
  parameter int DEPTH = 512,
  parameter int W     = 14,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic signed [W-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic signed [W-1:0] rdata
);

  logic signed [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/overlap_add.sv
// Overlap-add reassembly of 50%-overlapped windowed frames into one
// continuous, sequentially indexed sample stream.
module overlap_add #(
  parameter int I_BW       = 14,
  parameter int O_BW       = 14,
  parameter int FRAME_LEN  = mel_pkg::FRAME_LEN,
  parameter int NUM_FRAMES = mel_pkg::NUM_FRAMES
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic signed [I_BW-1:0]                      data_i,
  input  logic                                        di_en,
  input  logic [$clog2(FRAME_LEN)-1:0]                in_group_idx,
  input  logic [$clog2(NUM_FRAMES):0]                 in_group_num,
  output logic signed [O_BW-1:0]                      data_o,
  output logic                                        do_en,
  output logic [$clog2((NUM_FRAMES+1)*FRAME_LEN/2)-1:0] out_num,
  output logic                                        done,
  output logic                                        seq_err
);

  import mel_pkg::*;

  localparam int HOP   = FRAME_LEN / 2;
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int HOP_W = $clog2(HOP);
  localparam int NUM_W = $clog2(NUM_FRAMES) + 1;

  // Handshake: a sample and its tags are taken on any rising edge where
  // di_en=1 and the block is in RUN; there is no back-pressure. Each output
  // sample is a one-cycle do_en strobe carrying data_o and its index out_num.

  ola_state_t state;
  ola_state_t state_nxt;

  logic [IDX_W-1:0]       exp_idx;
  logic [NUM_W-1:0]       exp_num;
  logic [HOP_W-1:0]       flush_idx;
  logic                   accept;
  logic                   first_half;
  logic                   last_in;
  logic                   tag_bad;
  logic                   buf_we;
  logic                   emit;
  logic [HOP_W-1:0]       rd_addr;
  logic signed [I_BW-1:0] rd_data;
  logic signed [I_BW-1:0] addend;
  logic signed [31:0]     sum_sat;

  ola_buf #(
    .DEPTH (HOP),
    .W     (I_BW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (exp_idx[HOP_W-1:0]),
    .wdata (data_i),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Samples are placed by the expected counters, not the tags, so a bad tag
  // is flagged without misaligning the stream.
  always_comb begin
    accept     = (state == OLA_RUN) && di_en;
    first_half = ~exp_idx[IDX_W-1];
    last_in    = accept && (exp_idx == IDX_W'(FRAME_LEN - 1))
                        && (exp_num == NUM_W'(NUM_FRAMES - 1));
    tag_bad    = di_en && ((state != OLA_RUN) || (in_group_idx != exp_idx)
                                              || (in_group_num != exp_num));
    buf_we     = accept && !first_half;
    emit       = (accept && first_half) || (state == OLA_FLUSH);
    rd_addr    = (state == OLA_FLUSH) ? flush_idx : exp_idx[HOP_W-1:0];
    addend     = (state == OLA_RUN) ? data_i : '0;
    sum_sat    = sat_add({{(32-I_BW){rd_data[I_BW-1]}}, rd_data},
                         {{(32-I_BW){addend[I_BW-1]}}, addend},
                         O_BW);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OLA_RUN:   if (last_in) state_nxt = OLA_FLUSH;
      OLA_FLUSH: if (flush_idx == HOP_W'(HOP - 1)) state_nxt = OLA_DONE;
      OLA_DONE:  state_nxt = OLA_DONE;
      default:   state_nxt = OLA_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OLA_RUN;
      exp_idx   <= '0;
      exp_num   <= '0;
      flush_idx <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        exp_idx <= exp_idx + 1'b1;
        if (exp_idx == IDX_W'(FRAME_LEN - 1)) exp_num <= exp_num + 1'b1;
      end
      if (state == OLA_FLUSH) flush_idx <= flush_idx + 1'b1;
    end
  end

  // done trails the last flush strobe by one cycle because it follows state.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o  <= '0;
      do_en   <= 1'b0;
      out_num <= '0;
      done    <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      do_en <= emit;
      if (emit)    data_o  <= sum_sat[O_BW-1:0];
      if (do_en)   out_num <= out_num + 1'b1;
      if (tag_bad) seq_err <= 1'b1;
      if (state == OLA_DONE) done <= 1'b1;
    end
  end

endmodule
